uart_rx_fifo: RTL

//  Receive-side buffer directly downstream of the UART receiver controller. Captures one

---
 rtl/uart_rx_fifo.sv | 127 ++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// Receive FIFO between the UART receiver and the APB read path, with RTS hysteresis.
// Optional macro UART_RX_FIFO_ERR_EN stores the parity/framing flags with each character.
module uart_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int RTS_HI = 12,
  parameter int RTS_LO = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       wr_valid_i,
  input  logic [DATA_W-1:0]          wr_data_i,
  input  logic                       wr_perr_i,
  input  logic                       wr_ferr_i,
  input  logic                       rd_en_i,
  input  logic                       flush_i,
  input  logic                       ovr_clr_i,
  output logic [DATA_W-1:0]          rd_data_o,
  output logic                       rd_perr_o,
  output logic                       rd_ferr_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       overrun_o,
  output logic                       rts_no
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
`ifdef UART_RX_FIFO_ERR_EN
  localparam int EW = DATA_W + 2;
`else
  localparam int EW = DATA_W;
`endif

  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_overrun;
  logic          r_rts_n;

  logic          w_empty;
  logic          w_full;
  logic          w_do_wr;
  logic          w_do_rd;
  logic          w_ovr_set;
  logic [LW-1:0] w_level_nxt;
  logic [EW-1:0] w_wr_entry;
  logic [EW-1:0] w_head;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == LW'(DEPTH));

  // A read frees the slot the write needs, so a full FIFO still accepts a write alongside a pop.
  assign w_do_wr   = !flush_i && wr_valid_i && (!w_full || rd_en_i);
  assign w_do_rd   = !flush_i && rd_en_i && !w_empty;
  assign w_ovr_set = !flush_i && wr_valid_i && w_full && !rd_en_i;

  always_comb begin
    w_level_nxt = r_level;
    if (flush_i)
      w_level_nxt = '0;
    else if (w_do_wr && !w_do_rd)
      w_level_nxt = r_level + LW'(1);
    else if (w_do_rd && !w_do_wr)
      w_level_nxt = r_level - LW'(1);
  end

`ifdef UART_RX_FIFO_ERR_EN
  assign w_wr_entry = {wr_ferr_i, wr_perr_i, wr_data_i};
`else
  logic w_unused_err;
  assign w_unused_err = wr_perr_i ^ wr_ferr_i;
  assign w_wr_entry   = wr_data_i;
`endif

  always_ff @(posedge clk) begin
    if (w_do_wr)
      r_mem[r_wr_ptr] <= w_wr_entry;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_overrun <= 1'b0;
      r_rts_n   <= 1'b1;
    end else begin
      if (flush_i) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_do_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_do_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_level <= w_level_nxt;
      if (w_ovr_set)
        r_overrun <= 1'b1;
      else if (ovr_clr_i)
        r_overrun <= 1'b0;
      // Hysteresis: between the thresholds the previous RTS value is held.
      if (w_level_nxt >= LW'(RTS_HI))
        r_rts_n <= 1'b1;
      else if (w_level_nxt <= LW'(RTS_LO))
        r_rts_n <= 1'b0;
    end
  end

  assign w_head    = r_mem[r_rd_ptr];
  assign rd_data_o = w_empty ? '0 : w_head[DATA_W-1:0];
`ifdef UART_RX_FIFO_ERR_EN
  assign rd_perr_o = !w_empty && w_head[DATA_W];
  assign rd_ferr_o = !w_empty && w_head[DATA_W+1];
`else
  assign rd_perr_o = 1'b0;
  assign rd_ferr_o = 1'b0;
`endif

  assign empty_o   = w_empty;
  assign full_o    = w_full;
  assign level_o   = r_level;
  assign overrun_o = r_overrun;
  assign rts_no    = r_rts_n;

endmodule
